// File: rtl/vec_chunk_server.sv
// vec_chunk_server: buffers an int8 input vector loaded from a byte stream,
// serves it to the MV-product engine as WORKING_REGS-wide chunks, captures the
// engine's per-row result bytes and drains them downstream with backpressure.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_LOAD  | accepting input vector bytes from upstream
//   S_START | one-cycle chunk_ready pulse to the engine, pointers cleared
//   S_SERVE | presenting chunk at ptr, capturing result byte writes
//   S_DRAIN | streaming the captured result vector downstream
module vec_chunk_server #(
  parameter int VEC_LENGTH   = 8,
  parameter int OUT_LENGTH   = 8,
  parameter int WORKING_REGS = 4
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                load_valid,
  input  logic signed [7:0]                   load_data,
  output logic                                load_ready,
  output logic                                chunk_ready,
  output logic signed [WORKING_REGS*8-1:0]    chunk_data,
  input  logic                                req_chunk_in,
  input  logic                                req_chunk_ptr_rst,
  input  logic                                req_chunk_out,
  input  logic signed [7:0]                   write_in_data,
  output logic                                res_valid,
  output logic signed [7:0]                   res_data,
  output logic                                res_last,
  input  logic                                res_ready
);

  localparam int NCHUNKS = (VEC_LENGTH + WORKING_REGS - 1) / WORKING_REGS;
  localparam int LW      = $clog2(VEC_LENGTH + 1);
  localparam int OW      = $clog2(OUT_LENGTH + 1);
  localparam int PW      = $clog2(NCHUNKS + 1);

  localparam logic [LW-1:0] LOAD_LAST = LW'(VEC_LENGTH - 1);
  localparam logic [OW-1:0] OUT_LAST  = OW'(OUT_LENGTH - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(NCHUNKS - 1);

  typedef enum logic [1:0] {S_LOAD, S_START, S_SERVE, S_DRAIN} state_e;

  state_e          state_q;
  logic [LW-1:0]   load_idx_q;
  logic [OW-1:0]   out_idx_q;
  logic [OW-1:0]   drain_idx_q;
  logic [PW-1:0]   ptr_q;
  logic [7:0]      vec_q [VEC_LENGTH];
  logic [7:0]      res_q [OUT_LENGTH];

  // Vector storage widened to whole chunks; lanes past the vector read as zero.
  logic [NCHUNKS*WORKING_REGS*8-1:0] vec_pad;

  for (genvar e = 0; e < NCHUNKS * WORKING_REGS; e++) begin : g_pad
    if (e < VEC_LENGTH) begin : g_el
      assign vec_pad[e*8 +: 8] = vec_q[e];
    end else begin : g_zero
      assign vec_pad[e*8 +: 8] = 8'h00;
    end
  end

  // Control FSM plus all counters and storage; reset clears everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_LOAD;
      load_idx_q  <= '0;
      out_idx_q   <= '0;
      drain_idx_q <= '0;
      ptr_q       <= '0;
      for (int k = 0; k < VEC_LENGTH; k++) vec_q[k] <= '0;
      for (int k = 0; k < OUT_LENGTH; k++) res_q[k] <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (load_valid) begin
            for (int k = 0; k < VEC_LENGTH; k++)
              if (int'(load_idx_q) == k) vec_q[k] <= load_data;
            if (load_idx_q == LOAD_LAST) begin
              load_idx_q <= '0;
              state_q    <= S_START;
            end else begin
              load_idx_q <= load_idx_q + 1'b1;
            end
          end
        end
        S_START: begin
          ptr_q     <= '0;
          out_idx_q <= '0;
          state_q   <= S_SERVE;
        end
        S_SERVE: begin
          // Rewind wins over advance when both arrive together.
          if (req_chunk_ptr_rst) begin
            ptr_q <= '0;
          end else if (req_chunk_in) begin
            ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
          end
          if (req_chunk_out) begin
            for (int k = 0; k < OUT_LENGTH; k++)
              if (int'(out_idx_q) == k) res_q[k] <= write_in_data;
            if (out_idx_q == OUT_LAST) begin
              out_idx_q   <= '0;
              drain_idx_q <= '0;
              state_q     <= S_DRAIN;
            end else begin
              out_idx_q <= out_idx_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (res_ready) begin
            if (drain_idx_q == OUT_LAST) begin
              drain_idx_q <= '0;
              load_idx_q  <= '0;
              state_q     <= S_LOAD;
            end else begin
              drain_idx_q <= drain_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Chunk mux: selects the chunk addressed by the registered pointer.
  always_comb begin
    chunk_data = '0;
    for (int c = 0; c < NCHUNKS; c++)
      if (int'(ptr_q) == c) chunk_data = vec_pad[c*WORKING_REGS*8 +: WORKING_REGS*8];
  end

  // Drain mux: result byte addressed by the registered drain index.
  always_comb begin
    res_data = '0;
    for (int k = 0; k < OUT_LENGTH; k++)
      if (int'(drain_idx_q) == k) res_data = res_q[k];
  end

  assign load_ready  = (state_q == S_LOAD);
  assign chunk_ready = (state_q == S_START);
  assign res_valid   = (state_q == S_DRAIN);
  assign res_last    = (state_q == S_DRAIN) && (drain_idx_q == OUT_LAST);

endmodule

// File: tb/tb_vec_chunk_server.sv
// Testbench for vec_chunk_server: instance A (8 in, 8 out, 4 lanes) and
// instance B (6 in, 3 out, 4 lanes). Drain bytes are checked by monitors
// against scoreboard queues filled when result writes are issued.
module tb_vec_chunk_server;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  // Instance A signals
  logic a_load_valid = 0, a_req_in = 0, a_ptr_rst = 0, a_req_out = 0, a_res_ready = 0;
  logic [7:0] a_load_data = 0, a_wdata = 0;
  logic a_load_ready, a_chunk_ready, a_res_valid, a_res_last;
  logic [31:0] a_chunk;
  logic [7:0] a_res_data;

  // Instance B signals
  logic b_load_valid = 0, b_req_in = 0, b_ptr_rst = 0, b_req_out = 0, b_res_ready = 0;
  logic [7:0] b_load_data = 0, b_wdata = 0;
  logic b_load_ready, b_chunk_ready, b_res_valid, b_res_last;
  logic [31:0] b_chunk;
  logic [7:0] b_res_data;

  vec_chunk_server #(.VEC_LENGTH(8), .OUT_LENGTH(8), .WORKING_REGS(4)) ua (
    .clk_in(clk), .rst_in(rst),
    .load_valid(a_load_valid), .load_data(a_load_data), .load_ready(a_load_ready),
    .chunk_ready(a_chunk_ready), .chunk_data(a_chunk),
    .req_chunk_in(a_req_in), .req_chunk_ptr_rst(a_ptr_rst),
    .req_chunk_out(a_req_out), .write_in_data(a_wdata),
    .res_valid(a_res_valid), .res_data(a_res_data), .res_last(a_res_last),
    .res_ready(a_res_ready)
  );

  vec_chunk_server #(.VEC_LENGTH(6), .OUT_LENGTH(3), .WORKING_REGS(4)) ub (
    .clk_in(clk), .rst_in(rst),
    .load_valid(b_load_valid), .load_data(b_load_data), .load_ready(b_load_ready),
    .chunk_ready(b_chunk_ready), .chunk_data(b_chunk),
    .req_chunk_in(b_req_in), .req_chunk_ptr_rst(b_ptr_rst),
    .req_chunk_out(b_req_out), .write_in_data(b_wdata),
    .res_valid(b_res_valid), .res_data(b_res_data), .res_last(b_res_last),
    .res_ready(b_res_ready)
  );

  // Scoreboard entries: {last, data}
  logic [8:0] qa[$];
  logic [8:0] qb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: compare every accepted drain byte against the scoreboard.
  always @(negedge clk) begin
    if (!rst && a_res_valid && a_res_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_byte", 32'(a_res_data), 32'hFFFF_FFFF);
      end else begin
        logic [8:0] e;
        e = qa.pop_front();
        chk("a_res_data", 32'(a_res_data), 32'(e[7:0]));
        chk("a_res_last", 32'(a_res_last), 32'(e[8]));
      end
    end
  end

  // Monitor B: same scheme for the short instance.
  always @(negedge clk) begin
    if (!rst && b_res_valid && b_res_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_byte", 32'(b_res_data), 32'hFFFF_FFFF);
      end else begin
        logic [8:0] e;
        e = qb.pop_front();
        chk("b_res_data", 32'(b_res_data), 32'(e[7:0]));
        chk("b_res_last", 32'(b_res_last), 32'(e[8]));
      end
    end
  end

  task automatic a_load(input logic [7:0] first);
    for (int i = 0; i < 8; i++) begin
      a_load_valid = 1'b1;
      a_load_data  = first + 8'(i);
      tick();
    end
    a_load_valid = 1'b0;
  endtask

  task automatic a_write(input logic [7:0] d, input logic last, input logic push);
    a_req_out = 1'b1;
    a_wdata   = d;
    if (push) qa.push_back({last, d});
    tick();
    a_req_out = 1'b0;
  endtask

  task automatic b_write(input logic [7:0] d, input logic last);
    b_req_out = 1'b1;
    b_wdata   = d;
    qb.push_back({last, d});
    tick();
    b_req_out = 1'b0;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_load_ready"},  32'(a_load_ready),  32'd1);
    chk({tag, "_chunk_ready"}, 32'(a_chunk_ready), 32'd0);
    chk({tag, "_res_valid"},   32'(a_res_valid),   32'd0);
    chk({tag, "_res_last"},    32'(a_res_last),    32'd0);
    chk({tag, "_res_data"},    32'(a_res_data),    32'd0);
    chk({tag, "_chunk_data"},  a_chunk,            32'd0);
  endtask

  logic [7:0] a_bytes [8] = '{8'hFB, 8'h07, 8'h7F, 8'h80, 8'h00, 8'h01, 8'hFF, 8'h40};

  initial begin
    int n;
    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_idle_a("rst");
    chk("rst_b_load_ready", 32'(b_load_ready), 32'd1);

    // Load 1..8 and serve
    a_load(8'd1);
    chk("start_chunk_ready", 32'(a_chunk_ready), 32'd1);
    chk("start_load_ready",  32'(a_load_ready),  32'd0);
    chk("start_chunk0",      a_chunk,            32'h04030201);
    tick();
    chk("serve_chunk_ready_low", 32'(a_chunk_ready), 32'd0);
    chk("serve_chunk0_hold",     a_chunk,            32'h04030201);

    // Advance, with a stray load byte that must be ignored
    a_req_in = 1'b1; a_load_valid = 1'b1; a_load_data = 8'h55;
    tick();
    a_req_in = 1'b0; a_load_valid = 1'b0;
    chk("adv_chunk1", a_chunk, 32'h08070605);
    a_req_in = 1'b1;
    tick();
    a_req_in = 1'b0;
    chk("wrap_chunk0", a_chunk, 32'h04030201);
    a_req_in = 1'b1;
    tick();
    a_req_in = 1'b0;
    chk("adv2_chunk1", a_chunk, 32'h08070605);

    // Rewind takes priority over advance
    a_req_in = 1'b1; a_ptr_rst = 1'b1;
    tick();
    a_req_in = 1'b0; a_ptr_rst = 1'b0;
    chk("rewind_prio", a_chunk, 32'h04030201);

    // Capture eight result bytes
    for (int i = 0; i < 8; i++) a_write(a_bytes[i], (i == 7), 1'b1);
    chk("a_res_valid_after_last_write", 32'(a_res_valid), 32'd1);
    chk("a_load_ready_in_drain",        32'(a_load_ready), 32'd0);

    // Drain three bytes, stall three cycles, then finish
    a_res_ready = 1'b1;
    tick(); tick(); tick();
    a_res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(a_res_valid), 32'd1);
      chk("stall_data",  32'(a_res_data),  32'h80);
      chk("stall_last",  32'(a_res_last),  32'd0);
      tick();
    end
    a_res_ready = 1'b1;
    n = 0;
    while (a_res_valid && n < 20) begin
      tick();
      n++;
    end
    a_res_ready = 1'b0;
    chk("a_drain_cycles", 32'(n), 32'd5);
    chk("a_load_ready_after_drain", 32'(a_load_ready), 32'd1);
    chk("a_queue_empty", 32'(qa.size()), 32'd0);

    // Second vector: stray byte during SERVE must not have shifted it
    a_load(8'd11);
    chk("vec2_chunk0", a_chunk, 32'h0E0D0C0B);
    tick();
    a_req_in = 1'b1;
    tick();
    a_req_in = 1'b0;
    chk("vec2_chunk1", a_chunk, 32'h1211100F);

    // Reset mid-SERVE with ptr=1, out_idx=2
    a_write(8'h33, 1'b0, 1'b0);
    a_write(8'h44, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_a("midrst");
    a_load(8'd1);
    chk("reload_chunk_ready", 32'(a_chunk_ready), 32'd1);
    chk("reload_chunk0",      a_chunk,            32'h04030201);

    // Instance B: padding and short drain
    for (int i = 0; i < 6; i++) begin
      b_load_valid = 1'b1;
      b_load_data  = 8'(i + 1);
      tick();
    end
    b_load_valid = 1'b0;
    chk("b_chunk_ready", 32'(b_chunk_ready), 32'd1);
    chk("b_chunk0",      b_chunk,            32'h04030201);
    tick();
    b_req_in = 1'b1;
    tick();
    b_req_in = 1'b0;
    chk("b_pad_chunk1", b_chunk, 32'h00000605);
    b_res_ready = 1'b1;
    b_write(8'hFB, 1'b0);
    b_write(8'h07, 1'b0);
    b_write(8'h7F, 1'b1);
    chk("b_res_valid", 32'(b_res_valid), 32'd1);
    chk("b_first_byte", 32'(b_res_data), 32'hFB);
    tick(); tick(); tick();
    chk("b_res_valid_done", 32'(b_res_valid), 32'd0);
    chk("b_load_ready_next", 32'(b_load_ready), 32'd1);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);
    b_res_ready = 1'b0;

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vec_chunk_server.md
# vec_chunk_server

Activation-side partner of the matrix-vector product engine. Loads an int8 input vector from a byte stream and serves it to the engine as WorkingRegs-wide chunks on demand, with single-cycle advance and rewind. Captures the engine's one-byte-per-row result writes and drains the finished output vector as a byte stream with backpressure. Sits between the layer's upstream byte source and the next layer, one instance per MV-product stage.

## Interface
- VecLength, 8: input vector elements (int8). Must be ≥ 1.
- OutLength, 8: output vector elements, equal to the engine's output length. Must be ≥ 1.
- WorkingRegs, 4: chunk width in lanes. NChunks = ceil(VecLength/WorkingRegs).

Ports:
- clk_in  in  1  sole clock
- rst_in  in  1  synchronous, active-high reset
- load_valid  in  1  upstream byte valid
- load_data  in  8  signed upstream byte
- load_ready  out  1  block accepts a load byte
- chunk_ready  out  1  one-cycle start pulse to the engine's data-ready input
- chunk_data  out  WorkingRegs×8  signed current chunk; lane i = element ptr*WorkingRegs+i
- req_chunk_in  in  1  advance chunk pointer
- req_chunk_ptr_rst  in  1  rewind chunk pointer to 0
- req_chunk_out  in  1  result byte write strobe
- write_in_data  in  8  signed result byte
- res_valid  out  1  drain byte valid
- res_data  out  8  signed drain byte
- res_last  out  1  final drain byte
- res_ready  in  1  downstream accepts

## Operation
- States: LOAD, START, SERVE, DRAIN. Reset → LOAD.
- LOAD: load_ready=1. Each load_valid&load_ready cycle stores load_data at load_idx and increments it. Accepting element VecLength-1 → START.
- START: single cycle. chunk_ready=1, ptr=0, out_idx=0 → SERVE.
- SERVE: chunk_data = chunk at ptr. On req_chunk_ptr_rst, ptr←0, which takes priority over req_chunk_in. Otherwise, on req_chunk_in, ptr←ptr+1, wrapping from NChunks-1 to 0. Each req_chunk_out stores write_in_data at out_idx and increments it. Capturing element OutLength-1 → DRAIN. ptr is unaffected by req_chunk_out.
- DRAIN: res_valid=1, res_data=result[drain_idx], res_last = (drain_idx==OutLength-1). Each res_valid&res_ready increments drain_idx. Accepting the last byte → LOAD with load_idx=0.
- Padding: lanes of the final chunk with index ≥ VecLength read 0.
- Ignored inputs:
  - load_valid outside LOAD.
  - req_chunk_in, req_chunk_ptr_rst and req_chunk_out outside SERVE.
- No arithmetic is performed. Bytes are stored and returned bit-exact.
- Counter widths: $clog2(N+1) bits per counter, where N is that counter's limit.

## Timing
- Reset values:
  - load_ready=0 during the reset cycle, then 1 from the first cycle after.
  - chunk_ready=0, res_valid=0, res_last=0.
  - res_data=0 and chunk_data=0, because all storage is cleared.
  - ptr=0, all indices 0.
- load_ready, chunk_ready, res_valid and res_last are decoded from registered state.
- chunk_data and res_data are combinational reads of registered storage indexed by registered pointers.
- The last load byte accepted at edge N gives chunk_ready=1 in cycle N+1, with chunk_data = chunk 0 in both cycles N+1 and N+2.
- req_chunk_in sampled at edge E gives the new chunk during cycle E+1. This is the single-cycle chunk source the engine requires.
- chunk_ready is exactly one cycle wide. It must be low when the engine samples it at its final flush.
- The final req_chunk_out sampled at edge M gives res_valid=1 in cycle M+1.
- Throughput:
  - 1 load byte per cycle.
  - 1 drain byte per cycle while res_ready is held high.
  - res_data and res_last stay stable while res_valid&!res_ready.
- Reset mid-operation in any state: state returns to LOAD, storage is zeroed, and partial load or result data is discarded.

## Test plan
1. Load and serve (VecLength=8, WorkingRegs=4). Load 1..8 with no gaps.
   - chunk_ready pulses for 1 cycle after the last accept, and chunk_data={1,2,3,4}.
   - req_chunk_in gives {5,6,7,8}; a second req_chunk_in wraps back to {1,2,3,4}.
2. Rewind priority. In SERVE at ptr=1, assert req_chunk_in and req_chunk_ptr_rst in the same cycle.
   - Next cycle chunk_data={1,2,3,4}.
3. Padding (VecLength=6, WorkingRegs=4). Load 1..6, then req_chunk_in.
   - chunk_data={5,6,0,0}.
4. Capture and drain (OutLength=3). Send req_chunk_out pulses with -5, 7, 127, with res_ready held high.
   - res_data is -5, 7, 127 on consecutive cycles; res_last is high on 127 only.
   - load_ready=1 on the following cycle.
5. Backpressure. Drop res_ready for 3 cycles mid-drain.
   - res_data and res_last hold their values; no byte is skipped or duplicated.
   - Also assert load_valid during SERVE; the next vector's contents must be unaffected.
6. Reset mid-SERVE. Assert rst_in with ptr=1 and out_idx=2.
   - Next cycle: all outputs 0 except load_ready=1.
   - Reloading then gives correct chunk 0.
